// File: rtl/tt_lut_eval.sv
// tt_lut_eval: runtime-reprogrammable N_IN-input truth-table evaluator.
//   Evaluates input vectors over a valid/ready stream with a registered result.
//   The table is reloaded atomically from a serial MSB-first bit stream.
//   A sweep mode walks every input code 0..W-1 for characterisation.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready/in_data      input vector stream (in_data[0] = index LSB)
//   out_valid/out_ready            result stream
//   out_data/out_idx/out_last      table bit, index that produced it, final sweep entry
//   cfg_valid/cfg_ready/cfg_bit/cfg_last  serial table load; cfg_err = bad bit count
//   tt_active                      currently active table
//   sweep_start/sweep_busy/sweep_done     sweep control and status
module tt_lut_eval #(
  parameter int                      N_IN     = 4,
  parameter logic [(1<<N_IN)-1:0]    TT_RESET = 16'h1858
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_data,
  output logic [N_IN-1:0]        out_idx,
  output logic                   out_last,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic                   cfg_bit,
  input  logic                   cfg_last,
  output logic                   cfg_err,
  output logic [(1<<N_IN)-1:0]   tt_active,
  input  logic                   sweep_start,
  output logic                   sweep_busy,
  output logic                   sweep_done
);
  localparam int W  = 1 << N_IN;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_nx;

  logic [W-1:0]    shadow;
  logic [CW-1:0]   cfg_cnt;
  logic [N_IN-1:0] sw_cnt;

  logic slot_free, in_fire, sw_load, sw_final, cfg_fire, cnt_ok;

  assign slot_free  = ~out_valid | out_ready;
  // A same-cycle sweep_start wins over an input vector.
  assign in_ready   = (state == IDLE) & slot_free & ~sweep_start;
  assign cfg_ready  = (state == IDLE);
  assign sweep_busy = (state == SWEEP);
  assign in_fire    = in_valid & in_ready;
  assign sw_load    = (state == SWEEP) & slot_free;
  assign sw_final   = sw_load & (&sw_cnt);
  assign cfg_fire   = cfg_valid & cfg_ready;
  // The bit being shifted in now is counted: a full load has W-1 prior bits.
  assign cnt_ok     = (cfg_cnt + CW'(1)) == CW'(W);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sweep_start) state_nx = SWEEP;
      SWEEP:   if (sw_final)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Sweep counter stops at W-1 and is rearmed on the final entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sw_cnt <= '0;
    else if (sw_final) sw_cnt <= '0;
    else if (sw_load)  sw_cnt <= sw_cnt + 1'b1;
  end

  // Result register. Loads never overlap: eval only in IDLE, sweep only in SWEEP.
  // The result reads tt_active before any same-cycle commit lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= 1'b0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= sw_final;
      if (sw_load) begin
        out_valid <= 1'b1;
        out_data  <= tt_active[sw_cnt];
        out_idx   <= sw_cnt;
        out_last  <= &sw_cnt;
      end else if (in_fire) begin
        out_valid <= 1'b1;
        out_data  <= tt_active[in_data];
        out_idx   <= in_data;
        out_last  <= 1'b0;
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Serial table load into a shadow; committed only on an exact-length load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_active <= TT_RESET;
      shadow    <= '0;
      cfg_cnt   <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_fire) begin
        shadow <= {shadow[W-2:0], cfg_bit};
        if (cfg_last) begin
          cfg_cnt <= '0;
          if (cnt_ok) tt_active <= {shadow[W-2:0], cfg_bit};
          else        cfg_err   <= 1'b1;
        end else if (cfg_cnt != CW'(W)) begin
          cfg_cnt <= cfg_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_lut_eval.sv
// Directed bench for tt_lut_eval (N_IN=4) with an expected-result queue.
module tb_tt_lut_eval;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_data;
  logic        out_valid, out_ready, out_data, out_last;
  logic [3:0]  out_idx;
  logic        cfg_valid, cfg_ready, cfg_bit, cfg_last, cfg_err;
  logic [15:0] tt_active;
  logic        sweep_start, sweep_busy, sweep_done;

  tt_lut_eval #(.N_IN(4), .TT_RESET(16'h1858)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_bit(cfg_bit),
    .cfg_last(cfg_last), .cfg_err(cfg_err), .tt_active(tt_active),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       d;
    logic [3:0] idx;
    logic       last;
  } exp_t;

  exp_t        q[$];
  logic [15:0] model_tt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    chk("q_nonempty", 32'(q.size() != 0), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("out_data", out_data, e.d);
      chk("out_idx", out_idx, e.idx);
      chk("out_last", out_last, e.last);
      chk("sweep_done", sweep_done, e.last);
    end
  endtask

  // Called at a falling edge: settle, record handshakes of the coming edge, advance.
  task automatic tick();
    #1;
    if (in_valid && in_ready) q.push_back('{model_tt[in_data], in_data, 1'b0});
    if (out_valid && out_ready) pop_check();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic eval(input logic [3:0] v);
    in_valid = 1'b1; in_data = v;
    #1 chk("in_ready_eval", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [15:0] v, input int n, input logic exp_err);
    for (int i = n - 1; i >= 0; i--) begin
      cfg_valid = 1'b1; cfg_bit = v[i]; cfg_last = (i == 0);
      tick();
    end
    cfg_valid = 1'b0; cfg_last = 1'b0;
    chk("cfg_err", cfg_err, exp_err);
    tick();
    chk("cfg_err_pulse", cfg_err, 0);
  endtask

  // Starts a sweep and queues entries 0..n-1; runs n cycles after the start edge.
  task automatic sweep(input int n);
    sweep_start = 1'b1; in_valid = 1'b1; in_data = 4'd5;
    #1 chk("in_ready_sweep_start", in_ready, 0);
    tick();
    sweep_start = 1'b0;
    for (int k = 0; k < n; k++) q.push_back('{model_tt[k], 4'(k), k == 15});
    for (int k = 0; k < n; k++) begin
      #1;
      chk("sweep_busy", sweep_busy, 1);
      chk("in_ready_sweep", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_valid = 1'b0; cfg_bit = 1'b0; cfg_last = 1'b0; sweep_start = 1'b0;
    model_tt = 16'h1858;
    #12;
    chk("rst_tt", tt_active, 16'h1858);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", sweep_busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Evaluate reset table, back-to-back.
    eval(3); eval(4); eval(6); eval(11); eval(12);
    eval(0); eval(5); eval(15);
    drain();

    // Full sweep with no backpressure.
    sweep(16);
    drain();
    chk("sweep_busy_end", sweep_busy, 0);

    // Short load is rejected.
    load(16'h7fff, 15, 1'b1);
    chk("tt_after_bad", tt_active, 16'h1858);

    // Backpressure: result held while stalled.
    eval(3);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'd12;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 1);
      chk("stall_idx", out_idx, 3);
      chk("stall_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    drain();

    // Good load, then evaluate the new table.
    load(16'h8000, 16, 1'b0);
    model_tt = 16'h8000;
    chk("tt_after_load", tt_active, 16'h8000);
    eval(15); eval(14);
    drain();

    // Reset while the sweep shows idx 7.
    sweep(8);
    chk("pre_rst_valid", out_valid, 1);
    pop_check();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", sweep_busy, 0);
    chk("mid_rst_tt", tt_active, 16'h1858);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_q", q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_tt = 16'h1858;
    @(negedge clk);
    sweep(16);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
